rfx_pwmgen_cfg_seq: RTL and testbench
=====================================

// Module: rfx_pwmgen_cfg_seq
// PURPOSE
//  AXI4-Lite master that configures the rfx_pwmgen register bank (4 x 32-bit slave regs).
//  Software or local logic loads a 4-entry shadow table, then pulses start; the block writes
//  every entry to BASE_ADDR+4*i in order and, optionally, reads each back and compares.
//  Sits between the PS/control logic and the pwmgen S00_AXI port.
// PARAMETERS
//  BASE_ADDR   32'h43C0_0000  byte address of pwmgen register 0
//  NREG        4              number of registers sequenced (1..4)
//  TIMEOUT     255            max cycles waiting on any single AXI handshake
// PORTS
//  ACLK            in   1   clock; all logic rising-edge
//  ARESETN         in   1   asynchronous active-low reset
//  cfg_we          in   1   write shadow table entry cfg_idx with cfg_wdata
//  cfg_idx         in   2   shadow table index
//  cfg_wdata       in   32  shadow table data
//  start           in   1   begin sequence (single-cycle pulse, sampled in IDLE only)
//  verify          in   1   sampled with start: 1 = read back and compare each write
//  busy            out  1   high from cycle after start until done/error
//  done            out  1   one-cycle pulse on successful completion
//  error           out  1   sticky failure flag, cleared by next accepted start
//  err_idx         out  2   index of failing register (valid while error=1)
//  err_code        out  2   01 bad BRESP, 10 bad RRESP/compare mismatch, 11 timeout
//  m_axi_aw*/w*/b*/ar*/r*   standard AXI4-Lite master, 32-bit addr/data, prot=3'b000, wstrb=4'hF
// BEHAVIOUR
//  Reset: busy, done, error, all *valid, bready, rready = 0; err_idx, err_code = 0; FSM IDLE;
//   shadow table = 0. Reset mid-transaction drops valids immediately; no completion pulse.
//  FSM: IDLE -> WR (AWVALID and WVALID raised together, same cycle) -> WRESP -> [RD -> RDATA]
//   -> NEXT -> WR ... -> DONE (1 cycle, done=1) -> IDLE. Any failure -> ERR (1 cycle) -> IDLE.
//  WR: awvalid and wvalid each held until its own ready is seen; they drop independently;
//   leave WR when both accepted (order irrelevant). Address/data stable while valid high.
//  WRESP: bready=1; on bvalid, BRESP!=00 -> ERR code 01, else to RD (verify) or NEXT.
//  RD: arvalid held until arready. RDATA: rready=1; on rvalid, RRESP!=00 or rdata!=table[i]
//   -> ERR code 10.
//  Timeout: per-state counter reset on state entry; reaching TIMEOUT -> ERR code 11, valids
//   dropped (bus considered hung; software must reset slave).
//  Index i counts 0..NREG-1; after i=NREG-1 completes -> DONE. Address = BASE_ADDR + {i,2'b00}.
//  start while busy ignored; start in the same cycle as DONE/ERR ignored (accepted next IDLE).
//  cfg_we while busy ignored (table frozen during sequence); cfg_we in IDLE takes effect
//   next cycle; cfg_we and start in the same IDLE cycle: table write lands first, then start.
//  verify latched at start; changes during sequence have no effect.
//  Minimum latency with zero-wait slave, no verify: 3 cycles per register + 1 for DONE.
// TESTING
//  1 load 0101FFFF, abcd0001, dead0011, beef0011; start, verify=0, zero-wait BFM slave ->
//    4 writes to BASE+0/4/8/C in order, done pulse once, error=0, busy low after done.
//  2 same table, verify=1 -> 4 write/read pairs, read data equals table, done, error=0.
//  3 slave delays awready 5 cycles after wready -> wvalid drops after wready, awvalid held,
//    single write issued, data correct.
//  4 slave returns BRESP=10 on register 2 -> error=1, err_idx=2, err_code=01, no done,
//    register 3 never written; next start clears error.
//  5 slave never asserts arready (verify=1) -> after TIMEOUT cycles error=1, err_code=11,
//    arvalid=0; ARESETN pulsed low mid-write -> all valids 0 asynchronously, busy=0.
//  6 cfg_we to idx 1 while busy -> table unchanged, readback still matches original value.

Source files
------------

// File: rtl/rfx_pwmgen_cfg_seq.sv
// rfx_pwmgen_cfg_seq: AXI4-Lite master that copies a 4-entry shadow table into the
// rfx_pwmgen register bank, optionally reading each register back to confirm it.
module rfx_pwmgen_cfg_seq #(
  parameter logic [31:0] BASE_ADDR = 32'h43C0_0000,
  parameter int unsigned NREG      = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  // shadow table load / control
  input  logic        cfg_we,
  input  logic [1:0]  cfg_idx,
  input  logic [31:0] cfg_wdata,
  input  logic        start,
  input  logic        verify,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_idx,
  output logic [1:0]  err_code,
  // AXI4-Lite master
  output logic [31:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awprot,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  // Counter only needs to hold 0..TIMEOUT-1; expiry is detected on the last value.
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ErrBresp = 2'b01;
  localparam logic [1:0] ErrRead  = 2'b10;
  localparam logic [1:0] ErrTmo   = 2'b11;

  typedef enum logic [2:0] {
    StIdle, StWr, StWresp, StRd, StRdata, StNext, StDone, StErr
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic            verify_q, verify_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            error_q, error_d;
  logic [1:0]      err_idx_q, err_idx_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [31:0]     shadow_q [4];

  logic            tmo_expired;
  logic            fail;
  logic [1:0]      fail_code;
  logic [31:0]     reg_addr;

  assign tmo_expired = (tmo_q == TW'(TIMEOUT - 1));
  assign reg_addr    = BASE_ADDR + {28'd0, idx_q, 2'b00};

  // Shadow table: writable only while idle so a running sequence sees a frozen copy.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) shadow_q[i] <= '0;
    end else if (cfg_we && (state_q == StIdle)) begin
      shadow_q[cfg_idx] <= cfg_wdata;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      verify_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      tmo_q      <= '0;
      error_q    <= 1'b0;
      err_idx_q  <= '0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      verify_q   <= verify_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      tmo_q      <= tmo_d;
      error_q    <= error_d;
      err_idx_q  <= err_idx_d;
      err_code_q <= err_code_d;
    end
  end

  // Next-state logic; the timeout counter clears whenever the state changes.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    verify_d   = verify_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    tmo_d      = '0;
    error_d    = error_q;
    err_idx_d  = err_idx_q;
    err_code_d = err_code_q;
    fail       = 1'b0;
    fail_code  = '0;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StWr;
          idx_d      = '0;
          verify_d   = verify;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          error_d    = 1'b0;
          err_idx_d  = '0;
          err_code_d = '0;
        end
      end
      StWr: begin
        // Address and data channels complete independently, in either order.
        aw_done_d = aw_done_q | m_axi_awready;
        w_done_d  = w_done_q | m_axi_wready;
        if (aw_done_d && w_done_d) begin
          state_d = StWresp;
        end else if (tmo_expired) begin
          fail      = 1'b1;
          fail_code = ErrTmo;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      StWresp: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) begin
            fail      = 1'b1;
            fail_code = ErrBresp;
          end else begin
            state_d = verify_q ? StRd : StNext;
          end
        end else if (tmo_expired) begin
          fail      = 1'b1;
          fail_code = ErrTmo;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      StRd: begin
        if (m_axi_arready) begin
          state_d = StRdata;
        end else if (tmo_expired) begin
          fail      = 1'b1;
          fail_code = ErrTmo;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      StRdata: begin
        if (m_axi_rvalid) begin
          if ((m_axi_rresp != 2'b00) || (m_axi_rdata != shadow_q[idx_q])) begin
            fail      = 1'b1;
            fail_code = ErrRead;
          end else begin
            state_d = StNext;
          end
        end else if (tmo_expired) begin
          fail      = 1'b1;
          fail_code = ErrTmo;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      StNext: begin
        if (idx_q == 2'(NREG - 1)) begin
          state_d = StDone;
        end else begin
          state_d   = StWr;
          idx_d     = idx_q + 2'd1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (fail) begin
      state_d    = StErr;
      error_d    = 1'b1;
      err_idx_d  = idx_q;
      err_code_d = fail_code;
    end
  end

  // Bus and status outputs, decoded from registered state so reset drops them at once.
  always_comb begin
    m_axi_awaddr  = reg_addr;
    m_axi_awprot  = 3'b000;
    m_axi_awvalid = (state_q == StWr) && !aw_done_q;
    m_axi_wdata   = shadow_q[idx_q];
    m_axi_wstrb   = 4'hF;
    m_axi_wvalid  = (state_q == StWr) && !w_done_q;
    m_axi_bready  = (state_q == StWresp);
    m_axi_araddr  = reg_addr;
    m_axi_arprot  = 3'b000;
    m_axi_arvalid = (state_q == StRd);
    m_axi_rready  = (state_q == StRdata);
    busy          = (state_q inside {StWr, StWresp, StRd, StRdata, StNext});
    done          = (state_q == StDone);
    error         = error_q;
    err_idx       = err_idx_q;
    err_code      = err_code_q;
  end

endmodule

// File: tb/tb_rfx_pwmgen_cfg_seq.sv
// Bench for rfx_pwmgen_cfg_seq: an AXI4-Lite slave model records completed transfers and
// status events into an observed queue; a monitor pairs them with expected events.
module tb_rfx_pwmgen_cfg_seq;

  localparam int BOUND = 2000;

  typedef struct packed {
    logic [1:0]  kind;  // 0 write, 1 read, 2 done, 3 error
    logic [31:0] addr;  // error: err_idx
    logic [31:0] data;  // error: err_code
  } ev_t;

  logic tb_ACLK = 1'b0;
  logic ARESETN;
  logic cfg_we, start, verify;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_wdata;
  logic busy, done, error;
  logic [1:0] err_idx, err_code;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [3:0]  m_axi_wstrb;
  logic m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
  logic m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;
  logic [31:0] m_axi_rdata = 32'd0;

  int n_cmp = 0;
  int n_err = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];
  ev_t mon_o, mon_e;

  // Slave model knobs and state
  bit  bfm_w_en = 1'b1;
  bit  bfm_ar_en = 1'b1;
  int  bfm_aw_delay = 0;
  int  bfm_bad_idx = -1;
  bit  aw_got, w_got, bpend, b_fire, rpend, r_fire, new_wr, err_prev;
  int  wait_cnt, w_hold_err, aw_wait;
  logic [31:0] aw_addr, w_data, ar_addr;
  logic [31:0] bfm_mem [4];

  logic [31:0] tbl [4] = '{32'h0101_FFFF, 32'hABCD_0001, 32'hDEAD_0011, 32'hBEEF_0011};
  logic [31:0] adr [4] = '{32'h43C0_0000, 32'h43C0_0004, 32'h43C0_0008, 32'h43C0_000C};
  int lat;

  rfx_pwmgen_cfg_seq dut (
    .ACLK(tb_ACLK), .ARESETN(ARESETN),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_wdata(cfg_wdata),
    .start(start), .verify(verify),
    .busy(busy), .done(done), .error(error), .err_idx(err_idx), .err_code(err_code),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 tb_ACLK = ~tb_ACLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic void exp_ev(input logic [1:0] k, input logic [31:0] a,
                                 input logic [31:0] d);
    exp_q.push_back({k, a, d});
  endfunction

  // Slave model: decides readies/responses on the falling edge so they are stable at the
  // next rising edge; a valid&ready pair seen here is the handshake taken at that edge.
  always @(negedge tb_ACLK) begin
    if (!ARESETN) begin
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
      m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
      m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = 32'd0;
      aw_got = 0; w_got = 0; bpend = 0; b_fire = 0; rpend = 0; r_fire = 0;
      wait_cnt = 0; err_prev = 0;
      for (int i = 0; i < 4; i++) bfm_mem[i] = 32'd0;
    end else begin
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
      if (b_fire) begin
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00; b_fire = 0; aw_got = 0; w_got = 0;
      end
      if (r_fire) begin
        m_axi_rvalid = 1'b0; m_axi_rdata = 32'd0; r_fire = 0;
      end
      if (bpend) begin
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = (int'(aw_addr[3:2]) == bfm_bad_idx) ? 2'b10 : 2'b00;
        bpend = 0;
      end
      if (rpend) begin
        m_axi_rvalid = 1'b1; m_axi_rresp = 2'b00; m_axi_rdata = bfm_mem[ar_addr[3:2]];
        rpend = 0;
      end
      if (w_got && !aw_got) begin
        if (m_axi_wvalid) w_hold_err++;
        if (m_axi_awvalid) aw_wait++;
      end
      new_wr = 0;
      if (m_axi_wvalid && !w_got && bfm_w_en) begin
        m_axi_wready = 1'b1; w_got = 1; w_data = m_axi_wdata; wait_cnt = 0; new_wr = 1;
      end else if (w_got && !aw_got) begin
        wait_cnt++;
      end
      if (m_axi_awvalid && !aw_got &&
          (bfm_aw_delay == 0 || (w_got && wait_cnt >= bfm_aw_delay))) begin
        m_axi_awready = 1'b1; aw_got = 1; aw_addr = m_axi_awaddr; new_wr = 1;
      end
      if (new_wr && aw_got && w_got) begin
        bfm_mem[aw_addr[3:2]] = w_data;
        obs_q.push_back({2'd0, aw_addr, w_data});
        bpend = 1;
      end
      if (m_axi_arvalid && bfm_ar_en) begin
        m_axi_arready = 1'b1; ar_addr = m_axi_araddr; rpend = 1;
      end
      if (m_axi_bvalid && m_axi_bready) b_fire = 1;
      if (m_axi_rvalid && m_axi_rready) begin
        r_fire = 1;
        obs_q.push_back({2'd1, ar_addr, m_axi_rdata});
      end
      if (done) obs_q.push_back({2'd2, 32'd0, 32'd0});
      if (error && !err_prev) obs_q.push_back({2'd3, 30'd0, err_idx, 30'd0, err_code});
      err_prev = error;
    end
  end

  // Monitor: pairs every observed event with the oldest expected one.
  always @(posedge tb_ACLK) begin
    while (obs_q.size() != 0) begin
      mon_o = obs_q.pop_front();
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got kind %0d addr %h data %h, required no event",
                 mon_o.kind, mon_o.addr, mon_o.data);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_o !== mon_e) begin
          n_err++;
          $display("FAIL sb_event: got kind %0d addr %h data %h, required kind %0d addr %h data %h",
                   mon_o.kind, mon_o.addr, mon_o.data, mon_e.kind, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic load(input logic [1:0] i, input logic [31:0] d);
    @(negedge tb_ACLK);
    cfg_we = 1'b1; cfg_idx = i; cfg_wdata = d;
    @(negedge tb_ACLK);
    cfg_we = 1'b0;
  endtask

  // Pulses start and waits for done or error; lat counts rising edges after the start edge.
  task automatic run_seq(input logic v, input bit poke, output int l);
    @(negedge tb_ACLK);
    start = 1'b1; verify = v;
    @(negedge tb_ACLK);
    start = 1'b0; verify = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("err_clr_on_start", error, 1'b0);
    l = 0;
    while (!(done || error) && l < BOUND) begin
      @(negedge tb_ACLK);
      l++;
      if (poke && l == 3) begin cfg_we = 1'b1; cfg_idx = 2'd1; cfg_wdata = 32'h1234_5678; end
      if (poke && l == 4) cfg_we = 1'b0;
    end
    if (l >= BOUND) check("seq_end_bound", 32'd0, 32'd1);
    @(negedge tb_ACLK);
    check("busy_after_end", busy, 1'b0);
    check("done_single", done, 1'b0);
  endtask

  initial begin
    ARESETN = 1'b0; cfg_we = 1'b0; cfg_idx = 2'd0; cfg_wdata = 32'd0;
    start = 1'b0; verify = 1'b0;
    repeat (3) @(negedge tb_ACLK);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_err_idx", err_idx, 2'd0);
    check("rst_err_code", err_code, 2'd0);
    check("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 3'b000);
    check("rst_readies", {m_axi_bready, m_axi_rready}, 2'b00);
    check("prot_strb", {m_axi_awprot, m_axi_arprot, m_axi_wstrb}, {3'b000, 3'b000, 4'hF});
    ARESETN = 1'b1;
    for (int i = 0; i < 4; i++) load(2'(i), tbl[i]);

    // 1: plain writes, zero-wait slave: 3 cycles per register, DONE in the 13th cycle
    for (int i = 0; i < 4; i++) exp_ev(2'd0, adr[i], tbl[i]);
    exp_ev(2'd2, 32'd0, 32'd0);
    run_seq(1'b0, 1'b0, lat);
    check("t1_latency", lat, 12);
    check("t1_error", error, 1'b0);

    // 2: write + readback, 5 cycles per register
    for (int i = 0; i < 4; i++) begin
      exp_ev(2'd0, adr[i], tbl[i]);
      exp_ev(2'd1, adr[i], tbl[i]);
    end
    exp_ev(2'd2, 32'd0, 32'd0);
    run_seq(1'b1, 1'b0, lat);
    check("t2_latency", lat, 20);
    check("t2_error", error, 1'b0);

    // 3: awready 5 cycles after wready; WR lasts 6 cycles, 8 per register
    bfm_aw_delay = 5; aw_wait = 0; w_hold_err = 0;
    for (int i = 0; i < 4; i++) exp_ev(2'd0, adr[i], tbl[i]);
    exp_ev(2'd2, 32'd0, 32'd0);
    run_seq(1'b0, 1'b0, lat);
    check("t3_wvalid_dropped", w_hold_err, 0);
    check("t3_awvalid_held", aw_wait, 20);
    check("t3_latency", lat, 32);
    bfm_aw_delay = 0;

    // 6: cfg_we while busy must not alter the table being verified
    for (int i = 0; i < 4; i++) begin
      exp_ev(2'd0, adr[i], tbl[i]);
      exp_ev(2'd1, adr[i], tbl[i]);
    end
    exp_ev(2'd2, 32'd0, 32'd0);
    run_seq(1'b1, 1'b1, lat);
    check("t6_error", error, 1'b0);

    // 4: BRESP=10 on register 2 -> error code 01, register 3 never written
    bfm_bad_idx = 2;
    for (int i = 0; i < 3; i++) exp_ev(2'd0, adr[i], tbl[i]);
    exp_ev(2'd3, 32'd2, 32'd1);
    run_seq(1'b0, 1'b0, lat);
    check("t4_latency", lat, 8);
    check("t4_error_sticky", error, 1'b1);
    check("t4_err_idx", err_idx, 2'd2);
    check("t4_err_code", err_code, 2'd1);
    bfm_bad_idx = -1;
    for (int i = 0; i < 4; i++) exp_ev(2'd0, adr[i], tbl[i]);
    exp_ev(2'd2, 32'd0, 32'd0);
    run_seq(1'b0, 1'b0, lat);
    check("t4_rerun_latency", lat, 12);

    // 5a: arready never comes: 2 cycles of write, then 255 cycles stuck in RD
    bfm_ar_en = 1'b0;
    exp_ev(2'd0, adr[0], tbl[0]);
    exp_ev(2'd3, 32'd0, 32'd3);
    run_seq(1'b1, 1'b0, lat);
    check("t5_latency", lat, 257);
    check("t5_arvalid", m_axi_arvalid, 1'b0);
    check("t5_err_code", err_code, 2'd3);
    bfm_ar_en = 1'b1;

    // 5b: asynchronous reset in the middle of a stalled write
    bfm_w_en = 1'b0; bfm_aw_delay = 1000;
    @(negedge tb_ACLK);
    start = 1'b1;
    @(negedge tb_ACLK);
    start = 1'b0;
    check("t5_mid_wr", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
    #2 ARESETN = 1'b0;
    #1;
    check("t5_rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 3'b000);
    check("t5_rst_busy", busy, 1'b0);
    repeat (2) @(negedge tb_ACLK);
    ARESETN = 1'b1; bfm_w_en = 1'b1; bfm_aw_delay = 0;
    @(negedge tb_ACLK);
    check("t5_no_done", done, 1'b0);
    // reset also cleared the shadow table
    for (int i = 0; i < 4; i++) exp_ev(2'd0, adr[i], 32'd0);
    exp_ev(2'd2, 32'd0, 32'd0);
    run_seq(1'b0, 1'b0, lat);

    repeat (5) @(negedge tb_ACLK);
    check("sb_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
